// File: rtl/operand_fetch_latch.sv
// operand_fetch_latch: fetches 1-2 operand bytes under valid/ready with timeout; optional OPERAND_PARITY_EN adds mem_par/par_err
module operand_fetch_latch #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W = 8
) (
  input  logic       CLK,
  input  logic       notRST,
  input  logic       fetch_start,
  input  logic       fetch_len,
  input  logic       op_clear,
  input  logic [7:0] mem_data,
  input  logic       mem_valid,
`ifdef OPERAND_PARITY_EN
  input  logic       mem_par,
  output logic       par_err,
`endif
  output logic       mem_ready,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] notOP,
  output logic [7:0] notOPold
);
  typedef enum logic [1:0] {IDLE, WAIT_B0, WAIT_B1, FIN} state_t;
  state_t state, state_nx;
  logic rem2, to_q, acc, expire, start;
  logic [CNT_W-1:0] cnt;
  logic [7:0] op, op_old;
  assign mem_ready = state == WAIT_B0 || state == WAIT_B1;
  assign acc = mem_valid & mem_ready;
  assign start = state == IDLE && fetch_start;
  assign expire = mem_ready && !acc && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign timeout = to_q;
  assign notOP = ~op;
  assign notOPold = ~op_old;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (fetch_start ? WAIT_B0 : IDLE) :
               state == FIN  ? IDLE :
               acc           ? ((state == WAIT_B0 && rem2) ? WAIT_B1 : FIN) :
               expire        ? IDLE : state;
  end
  always_ff @(posedge CLK)
    if (!notRST) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge CLK) begin
    if (!notRST) begin
      rem2 <= 1'b0;
      to_q <= 1'b0;
      cnt <= '0;
      op <= 8'h00;
      op_old <= 8'h00;
    end else begin
      to_q <= expire;
      if (start) rem2 <= fetch_len;
      cnt <= (start || acc || expire) ? '0 : mem_ready ? cnt + 1'b1 : cnt;
      // clear beats a coincident accept for both registers
      if (op_clear) begin
        op <= 8'h00;
        op_old <= 8'h00;
      end else if (acc) begin
        op_old <= op;
        op <= mem_data;
      end
    end
  end
`ifdef OPERAND_PARITY_EN
  always_ff @(posedge CLK)
    if (!notRST) par_err <= 1'b0;
    else if (start) par_err <= 1'b0;
    else if (acc && !(^{mem_data, mem_par})) par_err <= 1'b1;
`endif
endmodule

// File: tb/tb_operand_fetch_latch.sv
// tb_operand_fetch_latch: directed plus randomized fetches checked against a transaction-level model
module tb_operand_fetch_latch;
  localparam int T = 15;
  logic CLK = 0, notRST = 0, fetch_start = 0, fetch_len = 0, op_clear = 0, mem_valid = 0;
  logic [7:0] mem_data = 0;
  logic mem_ready, busy, done, timeout;
  logic [7:0] notOP, notOPold;
  int total = 0, bad = 0;
  logic [7:0] m_op = 0, m_old = 0;
  logic m_perr = 0, inj = 0;
`ifdef OPERAND_PARITY_EN
  logic mem_par = 1, par_err;
`endif
  always #5 CLK = ~CLK;
  operand_fetch_latch #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .CLK(CLK), .notRST(notRST), .fetch_start(fetch_start), .fetch_len(fetch_len),
    .op_clear(op_clear), .mem_data(mem_data), .mem_valid(mem_valid),
`ifdef OPERAND_PARITY_EN
    .mem_par(mem_par), .par_err(par_err),
`endif
    .mem_ready(mem_ready), .busy(busy), .done(done), .timeout(timeout),
    .notOP(notOP), .notOPold(notOPold)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  function automatic logic rc(input int p);
    return $urandom_range(99) < p;
  endfunction
  task automatic chk_out(input string tag, input logic r, input logic b, input logic d, input logic t);
    chk({tag, ".ready"}, mem_ready, r);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".done"}, done, d);
    chk({tag, ".timeout"}, timeout, t);
    chk({tag, ".notOP"}, notOP, ~m_op);
    chk({tag, ".notOPold"}, notOPold, ~m_old);
`ifdef OPERAND_PARITY_EN
    chk({tag, ".par_err"}, par_err, m_perr);
`endif
  endtask
  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    mem_valid = v;
    mem_data = d;
    op_clear = c;
    fetch_start = 1'($urandom);
`ifdef OPERAND_PARITY_EN
    mem_par = ~^d ^ inj;
`endif
  endtask
  // one transaction: gN idle-bus cycles precede byte N; T consecutive idle cycles abort
  task automatic fetch(input bit two, input int g0, input int g1, input logic [7:0] b0,
                       input logic [7:0] b1, input int clr_pct, input bit clr_acc);
    int gaps[2];
    logic [7:0] bs[2];
    int n;
    gaps[0] = g0; gaps[1] = g1; bs[0] = b0; bs[1] = b1;
    n = two ? 2 : 1;
    fetch_start = 1; fetch_len = two; mem_valid = 1'($urandom); op_clear = rc(clr_pct);
    step();
    if (op_clear) begin m_op = 0; m_old = 0; end
    m_perr = 0;
    chk_out("start", 1, 1, 0, 0);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < gaps[i]; k++) begin
        drive(0, 8'($urandom), rc(clr_pct));
        step();
        if (op_clear) begin m_op = 0; m_old = 0; end
        if (k + 1 == T) begin
          chk_out("tmo", 0, 0, 0, 1);
          fetch_start = 0; op_clear = 0;
          step();
          chk_out("tmo_end", 0, 0, 0, 0);
          return;
        end
        chk_out("wait", 1, 1, 0, 0);
      end
      drive(1, bs[i], rc(clr_pct) | clr_acc);
      step();
      m_old = m_op; m_op = bs[i];
      if (op_clear) begin m_op = 0; m_old = 0; end
      if (inj) m_perr = 1;
      if (i == n - 1) chk_out("fin", 0, 1, 1, 0);
      else chk_out("b0", 1, 1, 0, 0);
    end
    fetch_start = 1'($urandom); mem_valid = 1'($urandom); op_clear = 0;
    step();
    chk_out("idle", 0, 0, 0, 0);
    fetch_start = 0; mem_valid = 0;
  endtask
  initial begin
    mem_valid = 1;
    step(); step();
    chk_out("reset", 0, 0, 0, 0);
    notRST = 1; mem_valid = 0;
    step();
    chk_out("post_reset", 0, 0, 0, 0);
    fetch(1, 0, 0, 8'h3C, 8'hA5, 0, 0);
    chk("tp_2byte.notOP", notOP, 8'h5A);
    chk("tp_2byte.notOPold", notOPold, 8'hC3);
    fetch(0, 0, 0, 8'h12, 8'h00, 0, 0);
    fetch(0, 5, 0, 8'h77, 8'h00, 0, 0);
    chk("tp_stall.notOP", notOP, 8'h88);
    chk("tp_stall.notOPold", notOPold, 8'hED);
    fetch(1, 0, 20, 8'h40, 8'h00, 0, 0);
    chk("tp_tmo.notOP", notOP, 8'hBF);
    fetch(0, T - 1, 0, 8'h5E, 8'h00, 0, 0);
    fetch(0, T, 0, 8'h61, 8'h00, 0, 0);
    fetch(1, 0, 0, 8'h11, 8'h99, 0, 1);
    chk("tp_clr.notOP", notOP, 8'hFF);
    fetch(1, 0, 0, 8'hC7, 8'h2B, 0, 0);
    fetch_start = 1; fetch_len = 1;
    step();
    fetch_start = 0; notRST = 0;
    step();
    m_op = 0; m_old = 0; m_perr = 0;
    notRST = 1;
    chk_out("mid_reset", 0, 0, 0, 0);
    step();
    chk_out("mid_reset2", 0, 0, 0, 0);
`ifdef OPERAND_PARITY_EN
    inj = 1;
    fetch(0, 0, 0, 8'h03, 8'h00, 0, 0);
    chk("tp_par.notOP", notOP, 8'hFC);
    inj = 0;
    fetch(0, 1, 0, 8'h55, 8'h00, 0, 0);
`endif
    for (int r = 0; r < 60; r++) begin
      int g0, g1;
      g0 = rc(8) ? $urandom_range(T + 3, T - 1) : $urandom_range(3);
      g1 = rc(8) ? $urandom_range(T + 3, T - 1) : $urandom_range(3);
      fetch(1'($urandom), g0, g1, 8'($urandom), 8'($urandom), 10, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
